// File: rtl/present_pkg.sv
// Shared constants, FSM encoding and key-schedule helpers for the PRESENT-80
// decryption core; PRESENT_KEYCACHE_EN enables the last-key/K32 cache in the top.
package present_pkg;

    localparam int ROUNDS = 31;
    localparam int RC_W   = 5;
    localparam int KEY_W  = 80;
    localparam int BLK_W  = 64;

    localparam logic [3:0] SBOX [16] = '{
        4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
        4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2
    };

    localparam logic [3:0] INV_SBOX [16] = '{
        4'h5, 4'hE, 4'hF, 4'h8, 4'hC, 4'h1, 4'h2, 4'hD,
        4'hB, 4'h4, 4'h6, 4'h3, 4'h0, 4'h7, 4'h9, 4'hA
    };

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_KEYEXP,
        ST_WHITEN,
        ST_ROUND,
        ST_DONE
    } state_e;

    function automatic logic [KEY_W-1:0] key_update(
        input logic [KEY_W-1:0] k,
        input logic [RC_W-1:0]  rc
    );
        logic [KEY_W-1:0] t;
        t          = {k[18:0], k[79:19]};
        t[79:76]   = SBOX[t[79:76]];
        t[19:15]   = t[19:15] ^ rc;
        return t;
    endfunction

    function automatic logic [KEY_W-1:0] key_update_inv(
        input logic [KEY_W-1:0] k,
        input logic [RC_W-1:0]  rc
    );
        logic [KEY_W-1:0] t;
        t          = k;
        t[19:15]   = t[19:15] ^ rc;
        t[79:76]   = INV_SBOX[t[79:76]];
        return {t[60:0], t[79:61]};
    endfunction

    function automatic logic [BLK_W-1:0] inv_sbox_layer(
        input logic [BLK_W-1:0] s
    );
        logic [BLK_W-1:0] t;
        for (int i = 0; i < 16; i++) begin
            t[4*i +: 4] = INV_SBOX[s[4*i +: 4]];
        end
        return t;
    endfunction

endpackage

// File: rtl/pbox_decrypt.sv
// Inverse PRESENT bit permutation: pure wiring, no logic.
// Output bit j takes input bit 16*j mod 63; bit 63 is fixed.
module pbox_decrypt
    import present_pkg::*;
(
    input  logic [BLK_W-1:0] data_i,
    output logic [BLK_W-1:0] data_o
);

    for (genvar j = 0; j < BLK_W - 1; j++) begin : g_bit
        assign data_o[j] = data_i[(16 * j) % 63];
    end

    assign data_o[BLK_W-1] = data_i[BLK_W-1];

endmodule

// File: rtl/present_decrypt_core.sv
// Iterative PRESENT-80 decryption: forward key expansion, whitening, 31 inverse
// rounds. Define PRESENT_KEYCACHE_EN to skip key expansion on a repeated key.
module present_decrypt_core
    import present_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [BLK_W-1:0] ciphertext,
    input  logic [KEY_W-1:0] key,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [BLK_W-1:0] plaintext,
    output logic             busy
);

    state_e           fsm_q, fsm_d;
    logic [KEY_W-1:0] key_q, key_d;
    logic [BLK_W-1:0] state_q, state_d;
    logic [RC_W-1:0]  rc_q, rc_d;
    logic [BLK_W-1:0] pinv;
    logic [KEY_W-1:0] kfwd;
    logic [KEY_W-1:0] kinv;
    logic             last_kexp;

    pbox_decrypt u_pbox (
        .data_i (state_q),
        .data_o (pinv)
    );

    assign kfwd      = key_update(key_q, rc_q);
    assign kinv      = key_update_inv(key_q, rc_q);
    assign last_kexp = (fsm_q == ST_KEYEXP) && (rc_q == RC_W'(ROUNDS));

`ifdef PRESENT_KEYCACHE_EN
    logic [KEY_W-1:0] last_key_q, last_key_d;
    logic [KEY_W-1:0] k32_q, k32_d;
    logic             cache_vld_q, cache_vld_d;
    logic             hit;

    assign hit = cache_vld_q && (key == last_key_q);

    // Validity drops on a miss so a half-built entry is never used.
    always_comb begin
        last_key_d  = last_key_q;
        k32_d       = k32_q;
        cache_vld_d = cache_vld_q;
        if (fsm_q == ST_IDLE && in_valid && !hit) begin
            last_key_d  = key;
            cache_vld_d = 1'b0;
        end
        if (last_kexp) begin
            k32_d       = kfwd;
            cache_vld_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_key_q  <= '0;
            k32_q       <= '0;
            cache_vld_q <= 1'b0;
        end else begin
            last_key_q  <= last_key_d;
            k32_q       <= k32_d;
            cache_vld_q <= cache_vld_d;
        end
    end
`endif

    always_comb begin
        fsm_d   = fsm_q;
        key_d   = key_q;
        state_d = state_q;
        rc_d    = rc_q;
        unique case (fsm_q)
            ST_IDLE: begin
                if (in_valid) begin
                    state_d = ciphertext;
                    key_d   = key;
                    rc_d    = RC_W'(1);
                    fsm_d   = ST_KEYEXP;
`ifdef PRESENT_KEYCACHE_EN
                    if (hit) begin
                        key_d = k32_q;
                        rc_d  = RC_W'(ROUNDS);
                        fsm_d = ST_WHITEN;
                    end
`endif
                end
            end
            ST_KEYEXP: begin
                key_d = kfwd;
                if (last_kexp) begin
                    fsm_d = ST_WHITEN;
                end else begin
                    rc_d = rc_q + RC_W'(1);
                end
            end
            ST_WHITEN: begin
                state_d = state_q ^ key_q[79:16];
                fsm_d   = ST_ROUND;
            end
            ST_ROUND: begin
                key_d   = kinv;
                state_d = inv_sbox_layer(pinv) ^ kinv[79:16];
                if (rc_q == RC_W'(1)) begin
                    rc_d  = '0;
                    fsm_d = ST_DONE;
                end else begin
                    rc_d = rc_q - RC_W'(1);
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    fsm_d = ST_IDLE;
                end
            end
            default: fsm_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q   <= ST_IDLE;
            key_q   <= '0;
            state_q <= '0;
            rc_q    <= '0;
        end else begin
            fsm_q   <= fsm_d;
            key_q   <= key_d;
            state_q <= state_d;
            rc_q    <= rc_d;
        end
    end

    assign in_ready  = (fsm_q == ST_IDLE);
    assign out_valid = (fsm_q == ST_DONE);
    assign busy      = (fsm_q == ST_KEYEXP) || (fsm_q == ST_WHITEN) ||
                       (fsm_q == ST_ROUND);
    assign plaintext = out_valid ? state_q : '0;

endmodule

// File: tb/tb_present_decrypt_core.sv
// Scoreboard bench for present_decrypt_core with a PRESENT-80 reference model.
// Build with +define+PRESENT_KEYCACHE_EN to check the key-cache latency.
`timescale 1ns/1ps
module tb_present_decrypt_core;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] ciphertext;
    logic [79:0] key;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] plaintext;
    logic        busy;

    always #5 clk = ~clk;

    present_decrypt_core dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .ciphertext (ciphertext),
        .key        (key),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .plaintext  (plaintext),
        .busy       (busy)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [63:0] pt;
        int          lat;
        int          acc;
        string       name;
    } exp_t;

    exp_t      sb[$];
    exp_t      cur;
    bit        seen      = 0;
    bit        orphan    = 0;
    bit        hs_prev   = 0;
    bit        rand_rdy  = 0;
    bit        stop      = 0;
    int        stall_req = 0;
    bit        mc_valid  = 0;
    bit [79:0] mc_key    = '0;
    int        last_lat  = 63;
    bit [79:0] pool [3];

    localparam bit [79:0] K0 = '0;
    localparam bit [79:0] K1 = '1;
    localparam bit [63:0] Z  = '0;
    localparam bit [63:0] F  = '1;

    bit [3:0] S [16] = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
                         4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};

    // Reference model, built from the published cipher description.
    function automatic int perm(input int i);
        return (i == 63) ? 63 : (16 * i) % 63;
    endfunction

    function automatic bit [3:0] s_inv(input bit [3:0] y);
        for (int x = 0; x < 16; x++) if (S[x] == y) return 4'(x);
        return 4'h0;
    endfunction

    function automatic bit [79:0] sched(input bit [79:0] k, input int r);
        bit [4:0] r5;
        r5 = 5'(r);
        k = (k << 61) | (k >> 19);
        k[79:76] = S[k[79:76]];
        k[19:15] = k[19:15] ^ r5;
        return k;
    endfunction

    function automatic bit [63:0] m_encrypt(input bit [63:0] p, input bit [79:0] k);
        bit [63:0] s, t;
        s = p;
        for (int r = 1; r <= 31; r++) begin
            s = s ^ k[79:16];
            for (int n = 0; n < 16; n++) s[4*n +: 4] = S[s[4*n +: 4]];
            t = '0;
            for (int i = 0; i < 64; i++) t[perm(i)] = s[i];
            s = t;
            k = sched(k, r);
        end
        return s ^ k[79:16];
    endfunction

    function automatic bit [63:0] m_decrypt(input bit [63:0] c, input bit [79:0] k);
        bit [79:0] rk [1:32];
        bit [63:0] s, t;
        rk[1] = k;
        for (int r = 1; r <= 31; r++) rk[r+1] = sched(rk[r], r);
        s = c ^ rk[32][79:16];
        for (int r = 31; r >= 1; r--) begin
            for (int i = 0; i < 64; i++) t[i] = s[perm(i)];
            for (int n = 0; n < 16; n++) t[4*n +: 4] = s_inv(t[4*n +: 4]);
            s = t ^ rk[r][79:16];
        end
        return s;
    endfunction

    task automatic chk(input string nm, input logic [79:0] got, input logic [79:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %h want %h", nm, got, want);
        end
    endtask

    task automatic monitor();
        while (!stop) begin
            @(negedge clk);
            if (!rst_n) begin
                seen    = 0;
                orphan  = 0;
                hs_prev = 0;
            end else begin
                if (hs_prev) begin
                    chk("done_one_cycle", 80'(out_valid), 80'(0));
                    chk("ready_after_hs", 80'(in_ready), 80'(1));
                end
                if (out_valid && !seen) begin
                    seen = 1;
                    if (sb.size() == 0) begin
                        orphan = 1;
                        checks++;
                        errors++;
                        $display("FAIL unexpected_output got %h want none", plaintext);
                    end else begin
                        orphan = 0;
                        cur = sb.pop_front();
                        chk({cur.name, "_latency"}, 80'(cyc - cur.acc), 80'(cur.lat));
                    end
                end
                if (out_valid && !orphan) begin
                    chk({cur.name, "_plaintext"}, 80'(plaintext), 80'(cur.pt));
                    chk({cur.name, "_in_ready_low"}, 80'(in_ready), 80'(0));
                end
                if (out_valid && stall_req > 0) begin
                    out_ready = 1'b0;
                    stall_req--;
                end else begin
                    out_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
                end
                hs_prev = out_valid && out_ready;
                if (hs_prev) begin
                    seen   = 0;
                    orphan = 0;
                end
            end
        end
    endtask

    task automatic send(input logic [63:0] c, input logic [79:0] k,
                        input logic [63:0] pt, input string nm);
        exp_t e;
        int   w;
        w = 0;
        @(negedge clk);
        while (!in_ready && w < 400) begin
            @(negedge clk);
            w++;
        end
        chk({nm, "_accept"}, 80'(in_ready), 80'(1));
        if (!in_ready) return;
        e.lat = 63;
`ifdef PRESENT_KEYCACHE_EN
        if (mc_valid && mc_key == k) e.lat = 32;
        mc_valid = 1;
        mc_key   = k;
`endif
        e.pt     = pt;
        e.acc    = cyc + 1;
        e.name   = nm;
        last_lat = e.lat;
        sb.push_back(e);
        in_valid   = 1'b1;
        ciphertext = c;
        key        = k;
        @(negedge clk);
        in_valid   = 1'b0;
        ciphertext = {$urandom, $urandom};
        key        = {16'($urandom), $urandom, $urandom};
    endtask

    task automatic run();
        logic [63:0] p, c;
        logic [79:0] k;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", 80'(in_ready), 80'(1));
        chk("rst_out_valid", 80'(out_valid), 80'(0));
        chk("rst_busy", 80'(busy), 80'(0));
        chk("rst_plaintext", 80'(plaintext), 80'(0));
        rst_n = 1'b1;

        send(64'h5579C1387B228445, K0, Z, "kat0");
        send(64'hE72C46C0F5945049, K1, Z, "kat1");
        send(64'hA112FFC72F68417B, K0, F, "kat2");
        stall_req = 10;
        send(64'h3333DCD3213210D2, K1, F, "kat3");
        send(64'h3333DCD3213210D2, K1, F, "kat3_rep");

        k = {16'($urandom), $urandom, $urandom};
        p = {$urandom, $urandom};
        send(m_encrypt(p, k), k, p, "garbage");
        for (int i = 0; i < 20; i++) begin
            chk("garbage_busy", 80'(busy), 80'(1));
            chk("garbage_in_ready", 80'(in_ready), 80'(0));
            in_valid   = 1'($urandom_range(0, 1));
            ciphertext = {$urandom, $urandom};
            key        = {16'($urandom), $urandom, $urandom};
            @(negedge clk);
        end
        in_valid = 1'b0;

        send(64'h5579C1387B228445, K0, Z, "pre_reset");
        repeat (last_lat - 21) @(posedge clk);
        #2;
        rst_n = 1'b0;
        sb.delete();
        seen     = 0;
        orphan   = 0;
        hs_prev  = 0;
        mc_valid = 0;
        @(negedge clk);
        chk("abort_out_valid", 80'(out_valid), 80'(0));
        chk("abort_in_ready", 80'(in_ready), 80'(1));
        chk("abort_busy", 80'(busy), 80'(0));
        chk("abort_plaintext", 80'(plaintext), 80'(0));
        @(negedge clk);
        rst_n = 1'b1;
        send(64'h3333DCD3213210D2, K1, F, "post_reset");

        rand_rdy = 1;
        for (int j = 0; j < 3; j++) pool[j] = {16'($urandom), $urandom, $urandom};
        for (int j = 0; j < 12; j++) begin
            k = pool[$urandom_range(0, 2)];
            if (j % 2 == 0) begin
                p = {$urandom, $urandom};
                c = m_encrypt(p, k);
            end else begin
                c = {$urandom, $urandom};
                p = m_decrypt(c, k);
            end
            send(c, k, p, $sformatf("rnd%0d", j));
        end

        for (int i = 0; i < 3000 && (sb.size() != 0 || seen); i++) @(negedge clk);
        chk("drain_queue_empty", 80'(sb.size()), 80'(0));
    endtask

    initial begin
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        ciphertext = '0;
        key        = '0;
        out_ready  = 1'b1;
        fork
            monitor();
        join_none
        run();
        stop = 1;
        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule
